// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame receiver: state encoding, sync default,
// checksum width and a saturating increment helper.
package serial_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;
    localparam logic [1:0] S_COMMIT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_PAYLOAD = S_PAYLOAD,
        ST_CHECK   = S_CHECK,
        ST_COMMIT  = S_COMMIT
    } state_e;

    localparam int         CHECKSUM_W        = 8;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// Idle-cycle counter for an open frame; expired_o pulses for the cycle in which
// the count sits at TIMEOUT_CYCLES-1 with no clear.
module frame_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 8388608
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int             W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;

    assign expired_o = enable_i && !clear_i && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear_i || !enable_i || expired_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/serial_frame_receive.sv
// Assembles received bytes into PAYLOAD_BYTES frames (optional sync byte and
// trailing checksum) and commits only verified frames to the payload register.
module serial_frame_receive
    import serial_pkg::*;
#(
    parameter int         PAYLOAD_BYTES  = 44,
    parameter bit         SYNC_EN        = 1'b1,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter bit         CHECKSUM_EN    = 1'b1,
    parameter int         TIMEOUT_CYCLES = 8388608
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic [8*PAYLOAD_BYTES-1:0]   payload,
    output logic                         load_flag,
    output logic                         payload_valid,
    output logic                         frame_error,
    output logic                         frame_timeout,
    output logic [7:0]                   error_count,
    output logic                         busy
);

    localparam int              PW       = 8 * PAYLOAD_BYTES;
    localparam int              CW       = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [CW-1:0]   LAST_IDX = CW'(PAYLOAD_BYTES - 1);
    localparam state_e          DONE_ST  = CHECKSUM_EN ? ST_CHECK : ST_COMMIT;

    state_e                  state_q;
    logic [PW-1:0]           shift_q;
    logic [PW-1:0]           payload_q;
    logic [CW-1:0]           cnt_q;
    logic [CHECKSUM_W-1:0]   sum_q;
    logic                    load_flag_q;
    logic                    pv_q;
    logic                    fe_q;
    logic                    ft_q;
    logic [7:0]              err_q;

    logic [PW-1:0]           shift_in;
    logic                    tmo_en;
    logic                    tmo_expired;

    assign shift_in = (shift_q << 8) | PW'(rx_data);

    // Only PAYLOAD/CHECK can time out; every entry into them is either from a
    // state where the counter is held at zero or on a byte, which clears it.
    assign tmo_en = (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);

    frame_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (rx_valid),
        .enable_i (tmo_en),
        .expired_o(tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            payload_q   <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            load_flag_q <= 1'b0;
            pv_q        <= 1'b0;
            fe_q        <= 1'b0;
            ft_q        <= 1'b0;
            err_q       <= '0;
        end else begin
            pv_q <= 1'b0;
            fe_q <= 1'b0;
            ft_q <= 1'b0;
            case (state_q)
                // COMMIT publishes the frame, then accepts a byte exactly like IDLE
                ST_IDLE, ST_COMMIT: begin
                    if (state_q == ST_COMMIT) begin
                        payload_q   <= shift_q;
                        load_flag_q <= ~load_flag_q;
                        pv_q        <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                    if (rx_valid) begin
                        if (SYNC_EN) begin
                            if (rx_data == SYNC_BYTE) begin
                                state_q <= ST_PAYLOAD;
                                cnt_q   <= '0;
                                sum_q   <= '0;
                            end
                        end else begin
                            shift_q <= shift_in;
                            cnt_q   <= CW'(1);
                            sum_q   <= rx_data;
                            state_q <= (PAYLOAD_BYTES == 1) ? DONE_ST : ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_valid) begin
                        shift_q <= shift_in;
                        cnt_q   <= cnt_q + 1'b1;
                        sum_q   <= sum_q + rx_data;
                        if (cnt_q == LAST_IDX) state_q <= DONE_ST;
                    end else if (tmo_expired) begin
                        state_q <= ST_IDLE;
                        ft_q    <= 1'b1;
                        err_q   <= sat_inc8(err_q);
                    end
                end
                ST_CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == sum_q) begin
                            state_q <= ST_COMMIT;
                        end else begin
                            state_q <= ST_IDLE;
                            fe_q    <= 1'b1;
                            err_q   <= sat_inc8(err_q);
                        end
                    end else if (tmo_expired) begin
                        state_q <= ST_IDLE;
                        ft_q    <= 1'b1;
                        err_q   <= sat_inc8(err_q);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign payload       = payload_q;
    assign load_flag     = load_flag_q;
    assign payload_valid = pv_q;
    assign frame_error   = fe_q;
    assign frame_timeout = ft_q;
    assign error_count   = err_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_receive.sv
// Randomized frame stimulus for two receiver configurations, checked against a
// frame-level model (byte lists, modular sums, commit/error bookkeeping).
module tb_serial_frame_receive;

    localparam int P0  = 44;
    localparam int PW0 = 8 * P0;
    localparam int T   = 100;

    logic             clk = 1'b0;
    logic             rst0, rst1;
    logic [7:0]       rxd0, rxd1;
    logic             rxv0, rxv1;
    logic [PW0-1:0]   pl0;
    logic [31:0]      pl1;
    logic             lf0, pv0, fe0, ft0, bz0;
    logic             lf1, pv1, fe1, ft1, bz1;
    logic [7:0]       ec0, ec1;

    always #5 clk = ~clk;

    serial_frame_receive #(
        .PAYLOAD_BYTES(P0), .SYNC_EN(1'b1), .SYNC_BYTE(8'hA5),
        .CHECKSUM_EN(1'b1), .TIMEOUT_CYCLES(T)
    ) dut0 (
        .clk(clk), .reset(rst0), .rx_data(rxd0), .rx_valid(rxv0),
        .payload(pl0), .load_flag(lf0), .payload_valid(pv0),
        .frame_error(fe0), .frame_timeout(ft0), .error_count(ec0), .busy(bz0)
    );

    serial_frame_receive #(
        .PAYLOAD_BYTES(4), .SYNC_EN(1'b0), .SYNC_BYTE(8'hA5),
        .CHECKSUM_EN(1'b0), .TIMEOUT_CYCLES(T)
    ) dut1 (
        .clk(clk), .reset(rst1), .rx_data(rxd1), .rx_valid(rxv1),
        .payload(pl1), .load_flag(lf1), .payload_valid(pv1),
        .frame_error(fe1), .frame_timeout(ft1), .error_count(ec1), .busy(bz1)
    );

    int total = 0;
    int bad   = 0;
    int n_pv0 = 0, n_fe0 = 0, n_ft0 = 0, n_pv1 = 0;

    // Frame-level model of dut0
    logic [7:0]     fb [P0];
    logic [PW0-1:0] m_pl0;
    logic           m_lf0;
    int             m_err0, m_pv0, m_fe0, m_ft0;

    always @(posedge clk) begin
        #1;
        if (pv0) n_pv0++;
        if (fe0) n_fe0++;
        if (ft0) n_ft0++;
        if (pv1) n_pv1++;
    end

    task automatic chk(input string tag, input logic [PW0-1:0] obs, input logic [PW0-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send0(input logic [7:0] b);
        rxv0 = 1'b1; rxd0 = b;
        @(negedge clk);
        rxv0 = 1'b0;
    endtask

    task automatic send1(input logic [7:0] b);
        rxv1 = 1'b1; rxd1 = b;
        @(negedge clk);
        rxv1 = 1'b0;
    endtask

    function automatic int sum8();
        int s = 0;
        for (int i = 0; i < P0; i++) s += fb[i];
        return s % 256;
    endfunction

    function automatic logic [PW0-1:0] pack();
        logic [PW0-1:0] r = '0;
        for (int i = 0; i < P0; i++) r[8*(P0-1-i) +: 8] = fb[i];
        return r;
    endfunction

    task automatic rand_fb();
        for (int i = 0; i < P0; i++) fb[i] = 8'($urandom);
    endtask

    task automatic gap(input int gmax);
        if (gmax > 0) idle($urandom_range(0, gmax));
    endtask

    // off==0 sends the correct checksum; anything else corrupts it by that amount
    task automatic send_frame0(input int off, input int gmax);
        logic [7:0] ck;
        ck = 8'(sum8() + off);
        send0(8'hA5);
        gap(gmax);
        for (int i = 0; i < P0; i++) begin
            send0(fb[i]);
            gap(gmax);
        end
        send0(ck);
        if (off % 256 == 0) begin
            m_pl0 = pack();
            m_lf0 = ~m_lf0;
            m_pv0++;
        end else begin
            m_fe0++;
            m_err0 = (m_err0 < 255) ? m_err0 + 1 : 255;
        end
    endtask

    task automatic check_state0(input string tag);
        idle(3);
        chk({tag, ".payload"}, pl0, m_pl0);
        chk({tag, ".load_flag"}, lf0, m_lf0);
        chk({tag, ".error_count"}, ec0, m_err0);
        chk({tag, ".pv_pulses"}, n_pv0, m_pv0);
        chk({tag, ".fe_pulses"}, n_fe0, m_fe0);
        chk({tag, ".ft_pulses"}, n_ft0, m_ft0);
        chk({tag, ".busy"}, bz0, 1'b0);
    endtask

    initial begin
        logic [7:0] g;
        int         off;
        rst0 = 1'b1; rst1 = 1'b1;
        rxv0 = 1'b0; rxv1 = 1'b0; rxd0 = '0; rxd1 = '0;
        m_pl0 = '0; m_lf0 = 1'b0;
        m_err0 = 0; m_pv0 = 0; m_fe0 = 0; m_ft0 = 0;
        idle(3);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);

        chk("reset.payload", pl0, '0);
        chk("reset.load_flag", lf0, 1'b0);
        chk("reset.pv", pv0, 1'b0);
        chk("reset.fe", fe0, 1'b0);
        chk("reset.ft", ft0, 1'b0);
        chk("reset.error_count", ec0, 8'd0);
        chk("reset.busy", bz0, 1'b0);

        // happy path with bytes 01..2C and one-cycle commit latency
        for (int i = 0; i < P0; i++) fb[i] = 8'(i + 1);
        send_frame0(0, 0);
        chk("lat.pv_early", pv0, 1'b0);
        chk("lat.payload_early", pl0, '0);
        chk("lat.busy_commit", bz0, 1'b1);
        @(negedge clk);
        chk("lat.pv", pv0, 1'b1);
        chk("lat.payload", pl0, m_pl0);
        chk("lat.load_flag", lf0, 1'b1);
        check_state0("happy");

        // same frame with checksum one too high
        send_frame0(1, 0);
        chk("badck.fe_pulse", fe0, 1'b1);
        chk("badck.busy", bz0, 1'b0);
        @(negedge clk);
        chk("badck.fe_single", fe0, 1'b0);
        check_state0("badck");

        // garbage ahead of the sync byte is dropped silently
        send0(8'h00); send0(8'hFF); send0(8'h5A);
        rand_fb();
        send_frame0(0, 2);
        check_state0("garbage");

        // partial frame then silence
        send0(8'hA5);
        for (int i = 0; i < 10; i++) send0(8'($urandom));
        idle(T - 1);
        chk("tmo.ft_early", ft0, 1'b0);
        chk("tmo.busy_early", bz0, 1'b1);
        idle(1);
        chk("tmo.ft", ft0, 1'b1);
        m_ft0++;
        m_err0++;
        chk("tmo.error_count", ec0, m_err0);
        rand_fb();
        send_frame0(0, 1);
        check_state0("after_tmo");

        // second sync byte lands in the COMMIT cycle
        rand_fb();
        send_frame0(0, 0);
        rand_fb();
        send_frame0(0, 0);
        check_state0("b2b");

        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                send0(g);
            end
            rand_fb();
            off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 255)) : 0;
            send_frame0(off, 3);
            check_state0($sformatf("rand%0d", k));
        end

        // push the error counter past saturation
        for (int k = 0; k < 260; k++) send_frame0(1, 0);
        check_state0("sat");
        chk("sat.value", ec0, 8'hFF);

        // dut1: unsynchronised 4-byte frames, no checksum, reset mid-frame
        send1(8'hAA); send1(8'hBB); send1(8'hCC); send1(8'hDD);
        idle(2);
        chk("nsync.payload", pl1, 32'hAABBCCDD);
        chk("nsync.load_flag", lf1, 1'b1);
        send1(8'h01); send1(8'h02);
        chk("rstmid.busy_before", bz1, 1'b1);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        chk("rstmid.payload", pl1, 32'h0);
        chk("rstmid.load_flag", lf1, 1'b0);
        chk("rstmid.busy", bz1, 1'b0);
        chk("rstmid.error_count", ec1, 8'd0);
        send1(8'h11); send1(8'h22); send1(8'h33); send1(8'h44);
        idle(2);
        chk("rstmid.payload2", pl1, 32'h11223344);
        chk("rstmid.load_flag2", lf1, 1'b1);
        chk("rstmid.pv_pulses", n_pv1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
